// File: rtl/pong_pkg.sv
// Shared match-controller types: FSM state encoding, match mode constants
// and a small compile-time helper used to size the delay counter.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PLAY       = 3'd1,
    ST_SERVE_WAIT = 3'd2,
    ST_PAUSE      = 3'd3,
    ST_OVER       = 3'd4
  } match_state_e;

  localparam logic MODE_TIMED    = 1'b0;
  localparam logic MODE_FIRST_TO = 1'b1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/match_delay_counter.sv
// Loadable down-counter shared by the SERVE_WAIT and OVER hold timers.
// o_done is high whenever the count sits at zero.
module match_delay_counter #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_done
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/match_controller.sv
// Match sequencing FSM for the pong game: scoring, serve timing, pause,
// timed / first-to-N end conditions and winner/draw reporting.
//
//   state       | meaning
//   ST_IDLE     | scores cleared, waiting for start
//   ST_PLAY     | ball live, stop low
//   ST_SERVE_WAIT | point scored, holding SERVE_DELAY cycles before serving
//   ST_PAUSE    | motion frozen until the next pause pulse
//   ST_OVER     | result shown for OVER_HOLD cycles
module match_controller
  import pong_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int SCORE_W     = 4,
  parameter int WIN_SCORE   = 9,
  parameter int SERVE_DELAY = 2,
  parameter int OVER_HOLD   = 2
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_start,
  input  logic                           i_pause,
  input  logic                           i_mode,
  input  logic                           i_time_up,
  input  logic [NUM_PLAYERS-1:0]         i_miss,
  output logic                           o_stop,
  output logic                           o_serve,
  output logic [2:0]                     o_state,
  output logic [NUM_PLAYERS*SCORE_W-1:0] o_scores,
  output logic [1:0]                     o_winner,
  output logic                           o_draw
);

  localparam int CNT_W = $clog2(max_int(SERVE_DELAY, OVER_HOLD)) + 1;
  localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_DELAY - 1);
  localparam logic [CNT_W-1:0]   OVER_LOAD  = CNT_W'(OVER_HOLD - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

  typedef logic [NUM_PLAYERS-1:0][SCORE_W-1:0] score_vec_t;

  match_state_e     r_state;
  match_state_e     w_next;
  logic             r_mode;
  logic             r_stop;
  logic             r_serve;
  logic             r_draw;
  logic [1:0]       r_winner;
  score_vec_t       r_scores;

  score_vec_t       w_upd;
  score_vec_t       w_final;
  logic             w_hit_win;
  logic             w_any_miss;
  logic [SCORE_W-1:0] w_best;
  logic [1:0]       w_winner;
  logic [2:0]       w_tie_cnt;
  logic             w_draw;

  logic             w_cnt_load;
  logic             w_cnt_en;
  logic             w_cnt_done;
  logic [CNT_W-1:0] w_cnt_val;

  assign w_any_miss = |i_miss;

  // Every player who did not miss gains a point, saturating at full scale.
  always_comb begin
    w_upd     = r_scores;
    w_hit_win = 1'b0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (!i_miss[i] && (r_scores[i] != SCORE_MAX)) begin
        w_upd[i] = r_scores[i] + SCORE_W'(1);
      end
      if (w_upd[i] >= WIN_VAL) begin
        w_hit_win = 1'b1;
      end
    end
  end

  // Result is judged on the scores that will be held during OVER.
  always_comb begin
    w_final   = w_any_miss ? w_upd : r_scores;
    w_best    = '0;
    w_winner  = '0;
    w_tie_cnt = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (w_final[i] > w_best) begin
        w_best   = w_final[i];
        w_winner = 2'(i);
      end
    end
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (w_final[i] == w_best) begin
        w_tie_cnt = w_tie_cnt + 3'd1;
      end
    end
    w_draw = (w_tie_cnt > 3'd1);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_next = ST_PLAY;
      end
      ST_PLAY: begin
        if (w_any_miss) begin
          w_next = ((r_mode == MODE_FIRST_TO) && w_hit_win) ? ST_OVER : ST_SERVE_WAIT;
        end else if ((r_mode == MODE_TIMED) && i_time_up) begin
          w_next = ST_OVER;
        end else if (i_pause) begin
          w_next = ST_PAUSE;
        end
      end
      ST_SERVE_WAIT: begin
        if (w_cnt_done) w_next = ST_PLAY;
      end
      ST_PAUSE: begin
        if (i_pause) w_next = ST_PLAY;
      end
      ST_OVER: begin
        if (w_cnt_done) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Both timed states are only ever entered from PLAY.
  assign w_cnt_load = (r_state == ST_PLAY) &&
                      ((w_next == ST_SERVE_WAIT) || (w_next == ST_OVER));
  assign w_cnt_val  = (w_next == ST_OVER) ? OVER_LOAD : SERVE_LOAD;
  assign w_cnt_en   = (r_state == ST_SERVE_WAIT) || (r_state == ST_OVER);

  match_delay_counter #(
    .W (CNT_W)
  ) u_delay (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .i_en       (w_cnt_en),
    .o_done     (w_cnt_done)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_mode   <= MODE_TIMED;
      r_stop   <= 1'b1;
      r_serve  <= 1'b0;
      r_scores <= '0;
      r_winner <= '0;
      r_draw   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_stop  <= (w_next != ST_PLAY);
      r_serve <= (w_next == ST_PLAY) &&
                 ((r_state == ST_IDLE) || (r_state == ST_SERVE_WAIT));
      if ((r_state == ST_IDLE) && i_start) begin
        r_mode <= i_mode;
      end
      if (w_next == ST_IDLE) begin
        r_scores <= '0;
        r_winner <= '0;
        r_draw   <= 1'b0;
      end else begin
        if ((r_state == ST_PLAY) && w_any_miss) begin
          r_scores <= w_upd;
        end
        if ((r_state == ST_PLAY) && (w_next == ST_OVER)) begin
          r_winner <= w_winner;
          r_draw   <= w_draw;
        end
      end
    end
  end

  assign o_state  = r_state;
  assign o_stop   = r_stop;
  assign o_serve  = r_serve;
  assign o_scores = r_scores;
  assign o_winner = r_winner;
  assign o_draw   = r_draw;

endmodule

// File: tb/tb_match_controller.sv
// Bench for match_controller: cycle model of the match rules checked every
// cycle, plus directed scenarios with literal expectations.
module tb_match_controller;
  import pong_pkg::*;

  localparam int NP   = 2;
  localparam int SW   = 4;
  localparam int WIN  = 3;
  localparam int SDLY = 4;
  localparam int OHLD = 6;
  localparam int SMAX = 15;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            pause = 1'b0;
  logic            mode = 1'b0;
  logic            time_up = 1'b0;
  logic [NP-1:0]   miss = '0;
  logic            stop;
  logic            serve;
  logic [2:0]      state;
  logic [NP*SW-1:0] scores;
  logic [1:0]      winner;
  logic            draw;

  int n_vec = 0;
  int n_err = 0;

  match_controller #(
    .NUM_PLAYERS (NP),
    .SCORE_W     (SW),
    .WIN_SCORE   (WIN),
    .SERVE_DELAY (SDLY),
    .OVER_HOLD   (OHLD)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_start   (start),
    .i_pause   (pause),
    .i_mode    (mode),
    .i_time_up (time_up),
    .i_miss    (miss),
    .o_stop    (stop),
    .o_serve   (serve),
    .o_state   (state),
    .o_scores  (scores),
    .o_winner  (winner),
    .o_draw    (draw)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the match rules.
  match_state_e m_st    = ST_IDLE;
  int           m_left  = 0;
  bit           m_mode  = 1'b0;
  int           m_sc[NP] = '{default: 0};
  bit           m_serve = 1'b0;
  int           m_win   = 0;
  bit           m_draw  = 1'b0;

  task automatic model_over();
    int best;
    int ties;
    best = -1;
    ties = 0;
    for (int i = 0; i < NP; i++) if (m_sc[i] > best) begin best = m_sc[i]; m_win = i; end
    for (int i = 0; i < NP; i++) if (m_sc[i] == best) ties++;
    m_draw = (ties > 1);
    m_st   = ST_OVER;
    m_left = OHLD;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = ST_IDLE; m_left = 0; m_mode = 1'b0; m_serve = 1'b0;
      m_win = 0; m_draw = 1'b0;
      for (int i = 0; i < NP; i++) m_sc[i] = 0;
    end else begin
      m_serve = 1'b0;
      case (m_st)
        ST_IDLE: begin
          for (int i = 0; i < NP; i++) m_sc[i] = 0;
          if (start) begin m_st = ST_PLAY; m_mode = mode; m_serve = 1'b1; end
        end
        ST_PLAY: begin
          if (miss != '0) begin
            bit reached;
            reached = 1'b0;
            for (int i = 0; i < NP; i++) begin
              if (!miss[i] && m_sc[i] < SMAX) m_sc[i] = m_sc[i] + 1;
              if (m_sc[i] >= WIN) reached = 1'b1;
            end
            if (m_mode && reached) model_over();
            else begin m_st = ST_SERVE_WAIT; m_left = SDLY; end
          end else if (!m_mode && time_up) begin
            model_over();
          end else if (pause) begin
            m_st = ST_PAUSE;
          end
        end
        ST_SERVE_WAIT: begin
          m_left--;
          if (m_left == 0) begin m_st = ST_PLAY; m_serve = 1'b1; end
        end
        ST_PAUSE: if (pause) m_st = ST_PLAY;
        ST_OVER: begin
          m_left--;
          if (m_left == 0) begin
            m_st = ST_IDLE;
            for (int i = 0; i < NP; i++) m_sc[i] = 0;
          end
        end
        default: m_st = ST_IDLE;
      endcase
    end
  end

  always @(posedge clk) begin
    logic [NP*SW-1:0] exp_sc;
    #1;
    for (int i = 0; i < NP; i++) exp_sc[i*SW +: SW] = SW'(m_sc[i]);
    chk("model_state", 32'(state), 32'(m_st));
    chk("model_stop",  32'(stop),  32'(m_st != ST_PLAY));
    chk("model_serve", 32'(serve), 32'(m_serve));
    chk("model_scores", 32'(scores), 32'(exp_sc));
    if (m_st == ST_OVER) begin
      chk("model_winner", 32'(winner), 32'(m_win));
      chk("model_draw",   32'(draw),   32'(m_draw));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic point(input logic [NP-1:0] m);
    miss = m;
    tick();
    miss = '0;
  endtask

  initial begin
    #12;
    chk("rst_state",  32'(state),  32'(ST_IDLE));
    chk("rst_stop",   32'(stop),   32'd1);
    chk("rst_serve",  32'(serve),  32'd0);
    chk("rst_scores", 32'(scores), 32'h0);
    chk("rst_winner", 32'(winner), 32'd0);
    chk("rst_draw",   32'(draw),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // start -> PLAY with a single serve pulse, timed mode
    mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_state", 32'(state), 32'(ST_PLAY));
    chk("start_serve", 32'(serve), 32'd1);
    chk("start_stop",  32'(stop),  32'd0);
    tick();
    chk("serve_1cyc",  32'(serve), 32'd0);

    // p0 misses: p1 scores, 4 cycles of SERVE_WAIT, then serve
    point(2'b01);
    chk("miss01_state",  32'(state),  32'(ST_SERVE_WAIT));
    chk("miss01_scores", 32'(scores), 32'h10);
    chk("miss01_stop",   32'(stop),   32'd1);
    for (int k = 0; k < 3; k++) begin tick(); chk("sw_hold", 32'(state), 32'(ST_SERVE_WAIT)); end
    tick();
    chk("sw_exit_state", 32'(state), 32'(ST_PLAY));
    chk("sw_exit_serve", 32'(serve), 32'd1);

    // both miss together with time_up: miss wins, no score change
    miss = 2'b11; time_up = 1'b1;
    tick();
    miss = '0; time_up = 1'b0;
    chk("miss11_state",  32'(state),  32'(ST_SERVE_WAIT));
    chk("miss11_scores", 32'(scores), 32'h10);
    tick(4);

    // pause, time_up ignored while paused, resume, then time_up ends match
    pause = 1'b1; tick(); pause = 1'b0;
    chk("pause_state", 32'(state), 32'(ST_PAUSE));
    time_up = 1'b1;
    tick(2);
    chk("pause_hold", 32'(state), 32'(ST_PAUSE));
    pause = 1'b1; tick(); pause = 1'b0;
    chk("resume_state", 32'(state), 32'(ST_PLAY));
    chk("resume_serve", 32'(serve), 32'd0);
    tick();
    time_up = 1'b0;
    chk("tu_over",   32'(state),  32'(ST_OVER));
    chk("tu_winner", 32'(winner), 32'd1);
    chk("tu_draw",   32'(draw),   32'd0);
    for (int k = 0; k < 5; k++) begin tick(); chk("over_hold", 32'(state), 32'(ST_OVER)); end
    tick();
    chk("over_idle",   32'(state),  32'(ST_IDLE));
    chk("over_clear",  32'(scores), 32'h0);

    // first-to-3: mode latched at start, time_up ignored
    mode = 1'b1; start = 1'b1; tick(); start = 1'b0; mode = 1'b0;
    time_up = 1'b1; tick(); time_up = 1'b0;
    chk("m1_tu_ignored", 32'(state), 32'(ST_PLAY));
    point(2'b01); tick(4);
    point(2'b01); tick(4);
    chk("m1_two", 32'(scores), 32'h20);
    point(2'b01);
    chk("m1_over",   32'(state),  32'(ST_OVER));
    chk("m1_scores", 32'(scores), 32'h30);
    chk("m1_winner", 32'(winner), 32'd1);
    chk("m1_draw",   32'(draw),   32'd0);
    tick(6);
    chk("m1_idle",  32'(state),  32'(ST_IDLE));
    chk("m1_clear", 32'(scores), 32'h0);

    // timed match tied 2:2 at time_up -> draw, winner 0
    mode = 1'b0; start = 1'b1; tick(); start = 1'b0;
    point(2'b01); tick(4);
    point(2'b10); tick(4);
    point(2'b01); tick(4);
    point(2'b10); tick(4);
    chk("tie_scores", 32'(scores), 32'h22);
    time_up = 1'b1; tick(); time_up = 1'b0;
    chk("tie_over",   32'(state),  32'(ST_OVER));
    chk("tie_draw",   32'(draw),   32'd1);
    chk("tie_winner", 32'(winner), 32'd0);
    tick(6);

    // saturation: p0 scores 17 times in a timed match
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 17; k++) begin point(2'b10); tick(4); end
    chk("sat_scores", 32'(scores), 32'h0F);

    // async reset in SERVE_WAIT abandons the match at once
    point(2'b01);
    chk("rst_sw_pre", 32'(state), 32'(ST_SERVE_WAIT));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state",  32'(state),  32'(ST_IDLE));
    chk("arst_scores", 32'(scores), 32'h0);
    chk("arst_stop",   32'(stop),   32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("post_rst_serve", 32'(serve), 32'd0);
      chk("post_rst_state", 32'(state), 32'(ST_IDLE));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
